clause_terminal: RTL and testbench

- Terminal cell at the end of one clause row in the clause array.
- Combines the summary signals from the clause's literal chain: satisfied flag, saturating free-literal count, conflict and all-false flags, and the max-level chain.
- Returns the registered control drives back into the literal chain: satisfied, implication, conflict, and the max level.
- One instance per clause, sitting next to the per-clause length register and the reason-tracking logic.

---
 rtl/clause_terminal_pkg.sv | 9 +
 rtl/clause_terminal.sv | 72 +++++++
 tb/tb_clause_terminal.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/clause_terminal_pkg.sv
// Shared encodings for the clause-array terminal logic.
// Free-literal counts saturate at FLC_MANY; 2'd3 is illegal and treated like FLC_MANY.
package clause_terminal_pkg;

  localparam logic [1:0] FLC_NONE = 2'd0;
  localparam logic [1:0] FLC_ONE  = 2'd1;
  localparam logic [1:0] FLC_MANY = 2'd2;

endpackage : clause_terminal_pkg

// File: rtl/clause_terminal.sv
// Terminal cell of one clause row: folds the literal-chain summaries into
// registered satisfied/implication/conflict/level drives back into the chain.
module clause_terminal
  import clause_terminal_pkg::*;
#(
  parameter int WIDTH_LVL   = 16,
  parameter int WIDTH_C_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   csat_i,
  output logic                   csat_drv_o,
  input  logic [1:0]             freelitcnt_i,
  input  logic [WIDTH_C_LEN-1:0] clause_len_i,
  output logic                   imp_drv_o,
  input  logic                   conflict_c_i,
  input  logic                   all_lit_false_i,
  output logic                   conflict_c_drv_o,
  input  logic [WIDTH_LVL-1:0]   cmax_lvl_i,
  output logic [WIDTH_LVL-1:0]   cmax_lvl_o,
  input  logic [31:0]            debug_cid_i
);

  logic                 w_valid;
  logic                 w_csat_d;
  logic                 w_imp_d;
  logic                 w_conf_d;
  logic [WIDTH_LVL-1:0] w_lvl_d;

  logic                 r_csat;
  logic                 r_imp;
  logic                 r_conf;
  logic [WIDTH_LVL-1:0] r_lvl;

  // The clause id only labels the row for debugging; it never affects the logic.
  logic w_unused_debug;
  assign w_unused_debug = ^debug_cid_i;

  // Satisfaction masks both implication and conflict, so they stay exclusive.
  always_comb begin
    w_valid  = (clause_len_i != '0);
    w_csat_d = csat_i & w_valid;
    w_imp_d  = w_valid & ~csat_i & (freelitcnt_i == FLC_ONE);
    w_conf_d = w_valid & ~csat_i & conflict_c_i & all_lit_false_i
             & (freelitcnt_i == FLC_NONE);
    w_lvl_d  = '0;
    if (w_imp_d || w_conf_d) begin
      w_lvl_d = cmax_lvl_i;
    end
  end

  // Single register stage breaks the combinational loop through the literal chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_csat <= 1'b0;
      r_imp  <= 1'b0;
      r_conf <= 1'b0;
      r_lvl  <= '0;
    end else begin
      r_csat <= w_csat_d;
      r_imp  <= w_imp_d;
      r_conf <= w_conf_d;
      r_lvl  <= w_lvl_d;
    end
  end

  assign csat_drv_o       = r_csat;
  assign imp_drv_o        = r_imp;
  assign conflict_c_drv_o = r_conf;
  assign cmax_lvl_o       = r_lvl;

endmodule : clause_terminal

// File: tb/tb_clause_terminal.sv
// Directed bench for clause_terminal: hand-computed vectors checked with
// immediate assertions one cycle after each input change.
module tb_clause_terminal;

  logic        clk;
  logic        rst;
  logic        csat_i;
  logic        csat_drv_o;
  logic [1:0]  freelitcnt_i;
  logic [3:0]  clause_len_i;
  logic        imp_drv_o;
  logic        conflict_c_i;
  logic        all_lit_false_i;
  logic        conflict_c_drv_o;
  logic [15:0] cmax_lvl_i;
  logic [15:0] cmax_lvl_o;
  logic [31:0] debug_cid_i;

  int testsRun;
  int testsFailed;

  clause_terminal #(
    .WIDTH_LVL  (16),
    .WIDTH_C_LEN(4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .csat_i          (csat_i),
    .csat_drv_o      (csat_drv_o),
    .freelitcnt_i    (freelitcnt_i),
    .clause_len_i    (clause_len_i),
    .imp_drv_o       (imp_drv_o),
    .conflict_c_i    (conflict_c_i),
    .all_lit_false_i (all_lit_false_i),
    .conflict_c_drv_o(conflict_c_drv_o),
    .cmax_lvl_i      (cmax_lvl_i),
    .cmax_lvl_o      (cmax_lvl_o),
    .debug_cid_i     (debug_cid_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOne(input string tag, input logic [15:0] observed,
                          input logic [15:0] expected);
    testsRun++;
    assert (observed === expected)
      else begin
        testsFailed++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  task automatic checkOutput(input string tag, input logic expCsat, input logic expImp,
                             input logic expConf, input logic [15:0] expLvl);
    checkOne({tag, ".csat"}, {15'd0, csat_drv_o}, {15'd0, expCsat});
    checkOne({tag, ".imp"},  {15'd0, imp_drv_o},  {15'd0, expImp});
    checkOne({tag, ".conf"}, {15'd0, conflict_c_drv_o}, {15'd0, expConf});
    checkOne({tag, ".lvl"},  cmax_lvl_o, expLvl);
  endtask

  task automatic applyStimulus(input logic len4Csat, input logic [1:0] flc,
                               input logic [3:0] len, input logic conf,
                               input logic alf, input logic [15:0] lvl);
    csat_i          = len4Csat;
    freelitcnt_i    = flc;
    clause_len_i    = len;
    conflict_c_i    = conf;
    all_lit_false_i = alf;
    cmax_lvl_i      = lvl;
    debug_cid_i     = debug_cid_i + 32'd1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b0;
    debug_cid_i = 32'd100;
    applyStimulus(1'b0, 2'd1, 4'd3, 1'b0, 1'b0, 16'd5);

    // Reset holds outputs low even with unit-clause inputs across edges.
    tick();
    checkOutput("reset_initial", 1'b0, 1'b0, 1'b0, 16'd0);
    rst = 1'b1;

    // Unit clause.
    tick();
    checkOutput("unit", 1'b0, 1'b1, 1'b0, 16'd5);

    // No combinational path: changing inputs does not move outputs before the edge.
    applyStimulus(1'b1, 2'd1, 4'd4, 1'b0, 1'b0, 16'd9);
    #2;
    checkOutput("no_comb_path", 1'b0, 1'b1, 1'b0, 16'd5);
    applyStimulus(1'b0, 2'd1, 4'd3, 1'b0, 1'b0, 16'd5);
    tick();
    checkOutput("unit_again", 1'b0, 1'b1, 1'b0, 16'd5);

    // Asynchronous reset mid-run while imp_drv_o is high.
    #2;
    rst = 1'b0;
    #1;
    checkOutput("reset_async", 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    checkOutput("reset_held", 1'b0, 1'b0, 1'b0, 16'd0);
    #2;
    rst = 1'b1;
    tick();
    checkOutput("reset_release", 1'b0, 1'b1, 1'b0, 16'd5);

    // Conflict.
    applyStimulus(1'b0, 2'd0, 4'd2, 1'b1, 1'b1, 16'd7);
    tick();
    checkOutput("conflict", 1'b0, 1'b0, 1'b1, 16'd7);

    // Satisfied overrides implication.
    applyStimulus(1'b1, 2'd1, 4'd4, 1'b0, 1'b0, 16'd11);
    tick();
    checkOutput("sat_over_imp", 1'b1, 1'b0, 1'b0, 16'd0);

    // Satisfied overrides conflict pattern.
    applyStimulus(1'b1, 2'd0, 4'd2, 1'b1, 1'b1, 16'd12);
    tick();
    checkOutput("sat_over_conf", 1'b1, 1'b0, 1'b0, 16'd0);

    // Empty slot with conflict-pattern inputs, and with csat high.
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 16'd7);
    tick();
    checkOutput("empty_conf", 1'b0, 1'b0, 1'b0, 16'd0);
    applyStimulus(1'b1, 2'd1, 4'd0, 1'b0, 1'b0, 16'd3);
    tick();
    checkOutput("empty_sat", 1'b0, 1'b0, 1'b0, 16'd0);

    // Many free literals and the illegal count.
    applyStimulus(1'b0, 2'd2, 4'd3, 1'b1, 1'b1, 16'd8);
    tick();
    checkOutput("many", 1'b0, 1'b0, 1'b0, 16'd0);
    applyStimulus(1'b0, 2'd3, 4'd3, 1'b1, 1'b1, 16'd8);
    tick();
    checkOutput("illegal3", 1'b0, 1'b0, 1'b0, 16'd0);

    // Inconsistent: no free literals but not all false.
    applyStimulus(1'b0, 2'd0, 4'd3, 1'b1, 1'b0, 16'd6);
    tick();
    checkOutput("inconsistent", 1'b0, 1'b0, 1'b0, 16'd0);

    // Conflict needs conflict_c_i as well.
    applyStimulus(1'b0, 2'd0, 4'd3, 1'b0, 1'b1, 16'd6);
    tick();
    checkOutput("no_conflict_flag", 1'b0, 1'b0, 1'b0, 16'd0);

    // Back-to-back sweep 2 -> 1 -> 0, each result one cycle after its input.
    applyStimulus(1'b0, 2'd2, 4'd5, 1'b0, 1'b0, 16'h1234);
    tick();
    checkOutput("sweep_many", 1'b0, 1'b0, 1'b0, 16'd0);
    applyStimulus(1'b0, 2'd1, 4'd5, 1'b0, 1'b0, 16'h1234);
    tick();
    checkOutput("sweep_imp", 1'b0, 1'b1, 1'b0, 16'h1234);
    applyStimulus(1'b0, 2'd0, 4'd5, 1'b1, 1'b1, 16'hBEEF);
    tick();
    checkOutput("sweep_conf", 1'b0, 1'b0, 1'b1, 16'hBEEF);
    applyStimulus(1'b0, 2'd1, 4'd15, 1'b0, 1'b0, 16'hFFFF);
    tick();
    checkOutput("max_len_lvl", 1'b0, 1'b1, 1'b0, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule : tb_clause_terminal
